// File: rtl/lane_pkg.sv
// Shared definitions for the lane merge slice.
//   lane_idx_w : width of a lane index ($clog2(n), never below 1)
//   XFER_CNT_W : width of the saturating transfer counter
//   merge_state_e : output-register occupancy state
package lane_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } merge_state_e;

  function automatic int lane_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_if.sv
// Valid/ready lane channel shared by the per-lane producers and the merge stage.
//   valid : producer holds a beat
//   ready : consumer takes the beat this cycle
//   data  : beat payload
interface lane_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport source (output valid, data, input ready);
  modport sink   (input valid, data, output ready);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req : per-lane request vector
//   ptr : index where the upward scan starts (wraps N-1 -> 0)
//   any : at least one request is set
//   idx : first requesting index at or after ptr (0 when none)
import lane_pkg::*;

module rr_pick #(
  parameter int N = 6,
  localparam int LW = lane_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  output logic          any,
  output logic [LW-1:0] idx
);

  int   cand;
  logic found;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = LW'(cand);
      end
    end
  end

endmodule

// File: rtl/lane_rr_merge.sv
// Round-robin merge of N lanes onto one registered output stream, tagging each
// beat with the lane it came from.
//   clk, rst          : clock, asynchronous active-high reset
//   lanes[N-1:0]      : input lanes (sink side)
//   out_valid/ready   : output handshake; out_valid is the register occupancy
//   out_data/out_lane : registered payload and lane of origin
//   xfer_count        : saturating count of beats accepted from lanes
//
// state    | meaning
// ST_EMPTY | output register free, out_valid=0
// ST_FULL  | output register holds a beat, out_valid=1
import lane_pkg::*;

module lane_rr_merge #(
  parameter int N = 6,
  parameter int W = 8,
  localparam int LW = lane_idx_w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  lane_if.sink                  lanes [N-1:0],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [LW-1:0]         out_lane,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  merge_state_e          state_q, state_d;
  logic [W-1:0]          data_q, data_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [LW-1:0]         ptr_q, ptr_d;
  logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

  logic [N-1:0]  req;
  logic [W-1:0]  lane_data [N];
  logic          pick_any;
  logic [LW-1:0] pick_idx;
  logic          ld;
  logic          lane_xfer;

  // Free register or draining this cycle; rst blocks grants while asserted.
  assign ld        = (state_q == ST_EMPTY) || out_ready;
  assign lane_xfer = !rst && ld && pick_any;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign req[g]         = lanes[g].valid;
    assign lane_data[g]   = lanes[g].data;
    assign lanes[g].ready = lane_xfer && (pick_idx == LW'(g));
  end

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    lane_d       = lane_q;
    ptr_d        = ptr_q;
    xfer_count_d = xfer_count_q;
    if (lane_xfer) begin
      state_d = ST_FULL;
      data_d  = lane_data[pick_idx];
      lane_d  = pick_idx;
      ptr_d   = (pick_idx == LW'(N - 1)) ? '0 : pick_idx + LW'(1);
      if (xfer_count_q != '1) xfer_count_d = xfer_count_q + XFER_CNT_W'(1);
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      lane_q       <= '0;
      ptr_q        <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      lane_q       <= lane_d;
      ptr_q        <= ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_valid  = (state_q == ST_FULL);
  assign out_data   = data_q;
  assign out_lane   = lane_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_lane_rr_merge.sv
// Directed bench for lane_rr_merge (N=6, W=8).
module tb_lane_rr_merge;

  localparam int N = 6;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_lane;
  logic [15:0]  xfer_count;

  logic [N-1:0] v;
  logic [W-1:0] d [N];
  logic [N-1:0] rdy;

  int checks = 0;
  int errors = 0;

  lane_if #(.W(W)) lanes [N-1:0] ();

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign lanes[i].valid = v[i];
    assign lanes[i].data  = d[i];
    assign rdy[i]         = lanes[i].ready;
  end

  lane_rr_merge #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .lanes      (lanes),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    v = '1;
    for (int i = 0; i < N; i++) d[i] = 8'hEE;
    #12;
    checks++;
    if (rdy !== 6'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 000000", rdy);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_lane !== 3'd0 || xfer_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%0d c=%h expected 0/00/0/0000",
               out_valid, out_data, out_lane, xfer_count);
    end
    @(negedge clk);
    v = '0;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      after_edge();
      checks++;
      if (out_valid !== 1'b0 || rdy !== 6'b0 || xfer_count !== 16'h0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got v=%b rdy=%b c=%h expected 0/000000/0000",
                 c, out_valid, rdy, xfer_count);
      end
    end
  endtask

  task automatic test_rotation();
    int exp_lane;
    @(negedge clk);
    for (int i = 0; i < N; i++) d[i] = 8'h10 + 8'(i);
    v = '1;
    out_ready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      exp_lane = b % N;
      #1;
      checks++;
      if (rdy !== (6'b1 << exp_lane)) begin
        errors++;
        $display("FAIL rot_ready%0d: got %b expected lane %0d only", b, rdy, exp_lane);
      end
      after_edge();
      checks++;
      if (out_valid !== 1'b1 || out_data !== (8'h10 + 8'(exp_lane)) || out_lane !== 3'(exp_lane)) begin
        errors++;
        $display("FAIL rot_beat%0d: got v=%b d=%h l=%0d expected 1/%h/%0d",
                 b, out_valid, out_data, out_lane, 8'h10 + 8'(exp_lane), exp_lane);
      end
      @(negedge clk);
    end
    checks++;
    if (xfer_count !== 16'd7) begin
      errors++;
      $display("FAIL rot_count: got %0d expected 7", xfer_count);
    end
  endtask

  task automatic test_wrap();
    int exp_lane;
    // last grant was lane 0; a single grant to lane 4 moves ptr to 5
    v = 6'b010000;
    d[4] = 8'h44;
    after_edge();
    checks++;
    if (out_lane !== 3'd4 || out_data !== 8'h44) begin
      errors++;
      $display("FAIL wrap_setup: got l=%0d d=%h expected 4/44", out_lane, out_data);
    end
    @(negedge clk);
    v = 6'b010010;
    d[1] = 8'h11;
    for (int b = 0; b < 4; b++) begin
      exp_lane = (b % 2 == 0) ? 1 : 4;
      #1;
      checks++;
      if (rdy !== (6'b1 << exp_lane)) begin
        errors++;
        $display("FAIL wrap_ready%0d: got %b expected lane %0d only", b, rdy, exp_lane);
      end
      after_edge();
      checks++;
      if (out_valid !== 1'b1 || out_lane !== 3'(exp_lane)) begin
        errors++;
        $display("FAIL wrap_beat%0d: got v=%b l=%0d expected 1/%0d", b, out_valid, out_lane, exp_lane);
      end
      @(negedge clk);
    end
    checks++;
    if (xfer_count !== 16'd12) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 12", xfer_count);
    end
  endtask

  task automatic test_stall();
    v = 6'b001000;
    d[3] = 8'hA5;
    out_ready = 1'b1;
    after_edge();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_lane !== 3'd3) begin
      errors++;
      $display("FAIL stall_load: got v=%b d=%h l=%0d expected 1/a5/3", out_valid, out_data, out_lane);
    end
    @(negedge clk);
    out_ready = 1'b0;
    d[3] = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (rdy !== 6'b0) begin
        errors++;
        $display("FAIL stall_ready%0d: got %b expected 000000", c, rdy);
      end
      after_edge();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || xfer_count !== 16'd13) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b d=%h c=%0d expected 1/a5/13",
                 c, out_valid, out_data, xfer_count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy !== 6'b001000) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 001000", rdy);
    end
    after_edge();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_lane !== 3'd3) begin
      errors++;
      $display("FAIL stall_next: got v=%b d=%h l=%0d expected 1/5a/3", out_valid, out_data, out_lane);
    end
    @(negedge clk);
    v = '0;
    after_edge();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    v = 6'b000100;
    d[2] = 8'h77;
    out_ready = 1'b0;
    after_edge();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      errors++;
      $display("FAIL mid_load: got v=%b d=%h expected 1/77", out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_lane !== 3'd0 || xfer_count !== 16'h0 || rdy !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%h l=%0d c=%h rdy=%b expected 0/00/0/0000/000000",
               out_valid, out_data, out_lane, xfer_count, rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    v = '1;
    for (int i = 0; i < N; i++) d[i] = 8'h20 + 8'(i);
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy !== 6'b000001) begin
      errors++;
      $display("FAIL mid_first_ready: got %b expected 000001", rdy);
    end
    after_edge();
    checks++;
    if (out_lane !== 3'd0 || out_data !== 8'h20) begin
      errors++;
      $display("FAIL mid_first_grant: got l=%0d d=%h expected 0/20", out_lane, out_data);
    end
    @(negedge clk);
    v = '0;
  endtask

  task automatic test_saturate();
    force dut.xfer_count_q = 16'hFFFE;
    #1;
    release dut.xfer_count_q;
    #1;
    checks++;
    if (xfer_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preset: got %h expected fffe", xfer_count);
    end
    @(negedge clk);
    v = 6'b000001;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      after_edge();
      checks++;
      if (xfer_count !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_xfer%0d: got %h expected ffff", t, xfer_count);
      end
      @(negedge clk);
    end
    v = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_saturate();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
